// File: rtl/adder8_result_fifo.sv
// adder8_result_fifo: DEPTH-entry show-ahead FIFO of 9-bit adder results {carry, sum} with a saturating carry counter.
// Optional running total of accepted results on acc_total when RESULT_ACCUM_EN is defined.
module adder8_result_fifo #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_sum,
    input  logic          in_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [8:0]    out_data,
    output logic [CW-1:0] count,
    output logic [7:0]    carry_cnt
`ifdef RESULT_ACCUM_EN
    ,
    output logic [15:0]   acc_total
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, wr_en;
    // handshake qualifiers; flush suppresses any same-cycle transfer
    always_comb begin
        in_ready  = count != CW'(DEPTH);
        out_valid = count != '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        wr_en     = push & ~flush;
        out_data  = out_valid ? mem[rd_ptr] : 9'h000;
    end
    // storage is deliberately left unreset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_carry, in_sum};
    end
    // pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push & ~pop) count <= count + CW'(1);
            else if (pop & ~push) count <= count - CW'(1);
        end
    end
    // saturating count of accepted carry-out results, survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) carry_cnt <= '0;
        else if (wr_en & in_carry & (carry_cnt != 8'hFF)) carry_cnt <= carry_cnt + 8'd1;
    end
`ifdef RESULT_ACCUM_EN
    // running modulo-2^16 total of accepted results, cleared by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_total <= '0;
        else if (flush) acc_total <= '0;
        else if (push) acc_total <= acc_total + {7'b0, in_carry, in_sum};
    end
`endif
endmodule

// File: tb/tb_adder8_result_fifo.sv
// tb_adder8_result_fifo: randomized and directed checks of adder8_result_fifo against a queue model.
module tb_adder8_result_fifo;
    localparam int DEPTH = 4;
    localparam int CW = 3;
    logic          clk = 0, rst = 1, flush = 0, in_valid = 0, in_carry = 0, out_ready = 0;
    logic [7:0]    in_sum = 0;
    logic          in_ready, out_valid;
    logic [8:0]    out_data;
    logic [CW-1:0] count;
    logic [7:0]    carry_cnt;
`ifdef RESULT_ACCUM_EN
    logic [15:0]   acc_total;
`endif
    int            tests = 0, fails = 0;
    logic [8:0]    q[$];
    int            cc = 0;
    logic [15:0]   acc = 0;

    adder8_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .carry_cnt(carry_cnt)
`ifdef RESULT_ACCUM_EN
        , .acc_total(acc_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        chk({tag, "_out_data"}, 32'(out_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
        chk({tag, "_carry_cnt"}, 32'(carry_cnt), 32'(cc));
`ifdef RESULT_ACCUM_EN
        chk({tag, "_acc"}, 32'(acc_total), 32'(acc));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [8:0] d, input logic ordy, input logic fl);
        bit push, pop;
        in_valid = v;
        {in_carry, in_sum} = d;
        out_ready = ordy;
        flush = fl;
        push = v && q.size() < DEPTH;
        pop = ordy && q.size() > 0;
        if (fl) begin
            q.delete();
            acc = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d);
                if (d[8] && cc < 255) cc++;
                acc = acc + 16'(d);
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [8:0] vals [5];
        vals = '{9'h013, 9'h0FF, 9'h0FF, 9'h100, 9'h007};
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 0;
        // single push visible one cycle later
        step("t1", 1, 9'h013, 0, 0);
        step("t2_push", 1, 9'h100, 0, 0);
        step("t2_pop", 0, 9'h000, 1, 0);
        chk("t2_head", 32'(out_data), 32'h100);
        step("t2_pop2", 0, 9'h000, 1, 0);
        chk("t2_cc", 32'(carry_cnt), 32'd1);
        // fill past full, then drain
        step("t3_flush", 0, 9'h000, 0, 1);
        foreach (vals[i]) begin
            step("t3_fill", 1, vals[i], 0, 0);
            if (i == 3) chk("t3_full", 32'(in_ready), 32'd0);
        end
        chk("t3_count", 32'(count), 32'd4);
        repeat (5) step("t3_drain", 0, 9'h000, 1, 0);
        chk("t3_empty", 32'(out_valid), 32'd0);
        // simultaneous push and pop at count 2
        step("t4_a", 1, 9'h021, 0, 0);
        step("t4_b", 1, 9'h142, 0, 0);
        repeat (6) step("t4_pp", 1, 9'($urandom), 1, 0);
        chk("t4_count", 32'(count), 32'd2);
`ifdef RESULT_ACCUM_EN
        step("t6_flush", 0, 9'h000, 0, 1);
        for (int i = 0; i < 4; i++) step("t6_push", 1, vals[i], 0, 0);
        chk("t6_acc", 32'(acc_total), 32'h0311);
        step("t6_flush2", 1, 9'h055, 0, 1);
        chk("t6_acc0", 32'(acc_total), 32'h0);
`endif
        // random traffic
        for (int i = 0; i < 400; i++)
            step("rnd", $urandom_range(0, 9) < 7, 9'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
        // asynchronous reset mid-cycle with 3 entries held
        step("t5_flush", 0, 9'h000, 0, 1);
        for (int i = 1; i < 4; i++) step("t5_fill", 1, vals[i], 0, 0);
        chk("t5_pre", 32'(count), 32'd3);
        #2 rst = 1;
        #1;
        q.delete();
        cc = 0;
        acc = 0;
        check_all("t5_rst");
        @(negedge clk);
        rst = 0;
        step("t5_resume", 1, 9'h1AA, 0, 0);
        step("t5_flushpush", 1, 9'h155, 0, 1);
        chk("t5_fl_count", 32'(count), 32'd0);
        step("t5_after", 0, 9'h000, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
